// File: rtl/spi_master.sv
// Mode-0, MSB-first, 8-bit SPI master with a valid/ready byte stream.
// SSEL stays asserted across bytes until the byte flagged tx_last completes.
module spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_NEXT,
    S_HOLD
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        last_q, last_d;
  logic        sck_q, sck_d;
  logic        ssel_q, ssel_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rxv_q, rxv_d;
  logic        busy_q, busy_d;
  logic        accept;

  assign accept = tx_valid && ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      last_q   <= 1'b0;
      sck_q    <= 1'b0;
      ssel_q   <= 1'b1;
      mosi_q   <= 1'b0;
      ready_q  <= 1'b0;
      rxd_q    <= '0;
      rxv_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      last_q   <= last_d;
      sck_q    <= sck_d;
      ssel_q   <= ssel_d;
      mosi_q   <= mosi_d;
      ready_q  <= ready_d;
      rxd_q    <= rxd_d;
      rxv_q    <= rxv_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    last_d   = last_q;
    sck_d    = sck_q;
    ssel_d   = ssel_q;
    mosi_d   = mosi_q;
    rxd_d    = rxd_q;
    rxv_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ssel_d = 1'b1;
        sck_d  = 1'b0;
        if (accept) begin
          tx_sh_d = tx_data;
          last_d  = tx_last;
          ssel_d  = 1'b0;
          mosi_d  = tx_data[7];
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          div_d    = '0;
          bitcnt_d = '0;
          state_d  = S_XFER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_XFER: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_sh_d  = {rx_sh_q[6:0], MISO};
            bitcnt_d = bitcnt_q + 3'd1;
          end else if (bitcnt_q != 3'd0) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end else begin
            // bitcnt wrapped on the 8th rise, so this fall closes the byte
            rxd_d   = rx_sh_q;
            rxv_d   = 1'b1;
            cnt_d   = '0;
            state_d = last_q ? S_HOLD : S_NEXT;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_NEXT: begin
        sck_d = 1'b0;
        if (accept) begin
          tx_sh_d  = tx_data;
          last_d   = tx_last;
          mosi_d   = tx_data[7];
          div_d    = '0;
          bitcnt_d = '0;
          state_d  = S_XFER;
        end
      end
      S_HOLD: begin
        sck_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Ready lags IDLE entry by one cycle so SSEL is high for at least a cycle
    ready_d = (state_d == S_NEXT) || (state_q == S_IDLE && state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign tx_ready = ready_q;
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;
  assign busy     = busy_q;
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = mosi_q;

endmodule

// File: doc/spi_master.md
# spi_master

Mode-0, MSB-first, 8-bit SPI master that drives SCK/SSEL/MOSI and samples MISO. It is the initiator counterpart to the design's SPI slave and connects FPGA logic to an external SPI device or to a second FPGA running the slave. Bytes are accepted on a valid/ready stream. SSEL stays low across consecutive bytes until the byte flagged `tx_last` has completed. Each completed byte returns the simultaneously received MISO byte.

## Interface
- `CLK_DIV`, 8: SCK half-period in `clk` cycles. Legal range is 2..255. When the peer is the FPGA SPI slave on a same-rate clock, ≥8 is required.
- `CS_SETUP`, 4: `clk` cycles from SSEL fall to the first SCK activity. Legal minimum is 1.
- `CS_HOLD`, 4: `clk` cycles from the last SCK fall to SSEL rise. Legal minimum is 1.

- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input 8: byte to transmit.
- `tx_last` input 1: qualifies `tx_data`. When high, SSEL deasserts after this byte.
- `tx_valid` input 1: upstream has a byte.
- `tx_ready` output 1: the block accepts a byte this cycle.
- `rx_data` output 8: last received byte. Held until the next byte completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: high whenever the block is not in IDLE.
- `SCK` output 1: SPI clock. Idles low.
- `SSEL` output 1: slave select, active low.
- `MOSI` output 1: master data out.
- `MISO` input 1: slave data in. Sampled directly; the slave changes it only after SCK falls.

## Operation
- **Registers.** All outputs are registered.
- **Reset values.** `SSEL`=1, `SCK`=0, `MOSI`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `busy`=0. State resets to IDLE.
- **IDLE.** `tx_ready`=1, SSEL=1.
  - On `tx_valid && tx_ready`, latch `tx_data` into the shift register and latch `tx_last`.
  - Drive SSEL=0 and MOSI=`tx_data[7]`, then go to SETUP.
- **SETUP.** Count `CS_SETUP` cycles with SCK=0, then go to XFER.
- **XFER.** A divider counts 0..`CLK_DIV`-1 and toggles SCK at the terminal count.
  - On the edge that drives SCK 0→1: shift MISO into the rx shift register LSB and increment `bitcnt`.
  - On the edge that drives SCK 1→0 for bits 1..7: shift the tx register left and set MOSI to the new MSB.
  - On the 8th falling edge: load `rx_data` from the rx shift register and pulse `rx_valid`.
  - Then go to HOLD if the latched last flag is 1, otherwise go to NEXT.
- **NEXT.** SSEL=0, SCK=0, `tx_ready`=1. Wait indefinitely for `tx_valid`.
  - On accept, latch the byte and last flag and set MOSI=bit 7.
  - Re-enter XFER with `bitcnt`=0 and the divider cleared. The first rise follows `CLK_DIV` cycles later.
- **HOLD.** Count `CS_HOLD` cycles with SCK=0 and SSEL=0.
  - Then set SSEL=1 and go to IDLE.
  - `tx_ready` rises on the next cycle, so SSEL stays high for at least 1 cycle.
- **Ignored input.** `tx_valid` is ignored while `tx_ready`=0. Upstream must hold data and `tx_last` stable until the handshake completes.
- **MOSI after last bit.** MOSI holds the last bit value through HOLD/NEXT and returns to 0 in IDLE.
- **Bit counter.** `bitcnt` is 3 bits and wraps 7→0 only at byte completion. No partial byte is ever emitted.

## Timing
- **Accept to SSEL.** SSEL falls on the same edge that completes the accept handshake.
- **First SCK rise.** Occurs `CS_SETUP`+`CLK_DIV` cycles after accept.
- **Byte duration.** 16·`CLK_DIV` cycles from XFER entry to the 8th fall. Default is 128.
- **Single-byte transaction.** SSEL low for `CS_SETUP`+16·`CLK_DIV`+`CS_HOLD` cycles. Default is 136.
- **rx_valid.** High in the cycle after the 8th fall edge, which is the same cycle as the first NEXT/HOLD cycle.
- **Back-to-back bytes.** `tx_ready` and `rx_valid` may be high together in NEXT. An accept in that cycle gives the minimum inter-byte gap: SCK low for `CLK_DIV`+1 cycles.
- **Reset mid-transfer.** Outputs return to reset values immediately and asynchronously: SSEL rises and SCK drops with no clock. The partial byte is discarded and no `rx_valid` is issued.
- **After reset release.** `tx_ready` rises on the first `clk` edge.

## Test plan
- **Single byte, echo.** Reset, then send 0xA5 with `tx_last`=1 and a behavioural slave returning 0x3C. Required response:
  - MOSI sampled on SCK rises = 1,0,1,0,0,1,0,1.
  - `rx_data`=0x3C with one `rx_valid` pulse.
  - SSEL low for exactly 136 cycles; 8 SCK rises.
- **Three-byte burst.** Send 0x01, 0x80, 0xFF with last on the third. Required response:
  - SSEL stays low across all bytes and there are 24 SCK rises.
  - 3 `rx_valid` pulses.
  - SSEL rises `CS_HOLD` cycles after the 24th fall.
- **Stalled upstream.** Same as the burst, but drop `tx_valid` in NEXT for 50 cycles. Required response:
  - SCK stays 0, SSEL stays 0, `tx_ready`=1 during the stall.
  - Transfer resumes with first rise `CLK_DIV` cycles after accept.
- **Loopback against the FPGA slave.** Use `CLK_DIV`=8 with MISO tied to slave output and the slave's data input at 0x5A with its flag=1. Required response:
  - The slave's byte register equals the sent byte.
  - From the second byte onward, `rx_data`=0x5A.
- **Reset mid-byte.** Assert `rst_n`=0 after 3 SCK rises. Required response:
  - SSEL=1, SCK=0, MOSI=0 immediately; no `rx_valid`.
  - `tx_ready`=1 on the first edge after release.
  - The next transaction is bit-exact.
- **Parameter corners.** `CLK_DIV`=2, `CS_SETUP`=1, `CS_HOLD`=1 with byte 0x96. Required response:
  - SCK period is 4 cycles.
  - SSEL low for 34 cycles.
  - Data is correct.
